// File: rtl/split_assign_driver.sv
`default_nettype none
// ============================================================================
// Module   : split_assign_driver
// Brief    : Loads a packed variable file from id/data beats, waits for an
//            external checker verdict, and returns it via valid/ready.
//            Optional macro SPLIT_DRV_CLEAR_EN zeroes the file per verdict.
// Revision : 1.0 - initial release
// ============================================================================
module split_assign_driver #(
  parameter int NUM_VARS = 50,
  parameter int VAR_W    = 8,
  parameter int CHK_LAT  = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_id,
  input  logic [VAR_W-1:0]          in_data,
  input  logic                      in_last,
  output logic [NUM_VARS*VAR_W-1:0] assign_bus,
  input  logic                      chk_x,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      res_sat,
  output logic                      res_complete,
  output logic                      res_err,
  output logic [7:0]                res_seq
);

  localparam int c_cnt_w = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_err_flag;
  logic [VAR_W-1:0]     r_vars [NUM_VARS];
  logic [NUM_VARS-1:0]  r_written;

  logic w_accept;
  logic w_in_range;
  logic w_res_hs;

  // Gated by rst so no beat can be taken while the block is being reset.
  assign in_ready   = (r_state == LOAD) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign w_in_range = ({1'b0, in_id} < 7'(NUM_VARS));
  assign w_res_hs   = res_valid && res_ready;

  // Variable file: written only in LOAD, so it is frozen in EVAL and RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_VARS; k++) begin
        r_vars[k] <= '0;
      end
      r_written <= '0;
    end else if (w_accept && w_in_range) begin
      for (int k = 0; k < NUM_VARS; k++) begin
        if (in_id == 6'(k)) begin
          r_vars[k]    <= in_data;
          r_written[k] <= 1'b1;
        end
      end
    end
`ifdef SPLIT_DRV_CLEAR_EN
    else if (w_res_hs) begin
      for (int k = 0; k < NUM_VARS; k++) begin
        r_vars[k] <= '0;
      end
      r_written <= '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_cnt        <= '0;
      r_err_flag   <= 1'b0;
      res_valid    <= 1'b0;
      res_sat      <= 1'b0;
      res_complete <= 1'b0;
      res_err      <= 1'b0;
      res_seq      <= 8'd0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (!w_in_range) begin
              r_err_flag <= 1'b1;
            end
            if (in_last) begin
              r_cnt   <= c_cnt_w'(CHK_LAT);
              r_state <= EVAL;
            end
          end
        end
        EVAL: begin
          // The final beat's write and error flag are already visible here.
          if (r_cnt == '0) begin
            res_sat      <= chk_x;
            res_complete <= &r_written;
            res_err      <= r_err_flag;
            res_valid    <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid  <= 1'b0;
            res_seq    <= res_seq + 8'd1;
            r_err_flag <= 1'b0;
            r_state    <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_VARS; k++) begin : g_bus
    assign assign_bus[k*VAR_W +: VAR_W] = r_vars[k];
  end

endmodule
`default_nettype wire

// File: tb/tb_split_assign_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_split_assign_driver
// Brief    : Directed self-checking bench for split_assign_driver; one
//            instance with CHK_LAT=0 and one with CHK_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_split_assign_driver;

`ifdef SPLIT_DRV_CLEAR_EN
  localparam bit c_clr = 1'b1;
`else
  localparam bit c_clr = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, in_last, chk_x, res_ready;
  logic [5:0]   in_id;
  logic [7:0]   in_data, res_seq;
  logic [399:0] assign_bus;
  logic         res_valid, res_sat, res_complete, res_err;

  logic         b_in_valid, b_in_ready, b_in_last, b_chk_x, b_res_ready;
  logic [5:0]   b_in_id;
  logic [7:0]   b_in_data, b_res_seq;
  logic [399:0] b_assign_bus;
  logic         b_res_valid, b_res_sat, b_res_complete, b_res_err;

  int n_vec = 0;
  int n_err = 0;

  split_assign_driver #(.NUM_VARS(50), .VAR_W(8), .CHK_LAT(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_data(in_data), .in_last(in_last),
    .assign_bus(assign_bus), .chk_x(chk_x), .res_valid(res_valid),
    .res_ready(res_ready), .res_sat(res_sat), .res_complete(res_complete),
    .res_err(res_err), .res_seq(res_seq)
  );

  split_assign_driver #(.NUM_VARS(50), .VAR_W(8), .CHK_LAT(3)) u_dut_lat3 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_id(b_in_id), .in_data(b_in_data), .in_last(b_in_last),
    .assign_bus(b_assign_bus), .chk_x(b_chk_x), .res_valid(b_res_valid),
    .res_ready(b_res_ready), .res_sat(b_res_sat), .res_complete(b_res_complete),
    .res_err(b_res_err), .res_seq(b_res_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] var_a(input int k);
    return assign_bus[k*8 +: 8];
  endfunction

  task automatic beat_a(input logic [5:0] id, input logic [7:0] d, input logic last);
    check("beat_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_id = id; in_data = d; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic beat_b(input logic [5:0] id, input logic [7:0] d, input logic last);
    b_in_valid = 1'b1; b_in_id = id; b_in_data = d; b_in_last = last;
    step();
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic hs_a();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_id = '0; in_data = '0; in_last = 1'b0;
    chk_x = 1'b0; res_ready = 1'b0;
    b_in_valid = 1'b0; b_in_id = '0; b_in_data = '0; b_in_last = 1'b0;
    b_chk_x = 1'b0; b_res_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(in_ready), 64'd1);
    check("post_rst_ready_b", 64'(b_in_ready), 64'd1);
    check("rst_seq", 64'(res_seq), 64'd0);
    check("rst_bus", 64'(|assign_bus), 64'd0);

    // CHK_LAT=3, ids 0..9 only; only the sampling cycle carries chk_x=1
    for (int i = 0; i < 10; i++) beat_b(6'(i), 8'(i + 1), i == 9);
    for (int k = 1; k <= 4; k++) begin
      check("lat3_wait", 64'(b_res_valid), 64'd0);
      b_chk_x = (k == 4);
      step();
    end
    b_chk_x = 1'b0;
    check("lat3_valid", 64'(b_res_valid), 64'd1);
    check("lat3_sat", 64'(b_res_sat), 64'd1);
    check("lat3_complete", 64'(b_res_complete), 64'd0);
    check("lat3_err", 64'(b_res_err), 64'd0);
    check("lat3_var9", 64'(b_assign_bus[72 +: 8]), 64'h0a);

    // Full assignment ids 0..49, CHK_LAT=0
    chk_x = 1'b1;
    for (int i = 0; i < 50; i++) beat_a(6'(i), 8'(i), i == 49);
    check("lat0_c1_valid", 64'(res_valid), 64'd0);
    step();
    check("lat0_valid", 64'(res_valid), 64'd1);
    check("full_sat", 64'(res_sat), 64'd1);
    check("full_complete", 64'(res_complete), 64'd1);
    check("full_err", 64'(res_err), 64'd0);
    check("full_seq", 64'(res_seq), 64'd0);
    check("full_var17", 64'(var_a(17)), 64'd17);

    // Backpressure: outputs frozen while res_ready=0
    for (int i = 0; i < 5; i++) begin
      chk_x = i[0];
      in_valid = 1'b1; in_id = 6'd5; in_data = 8'hff;
      step();
      check("hold_valid", 64'(res_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_sat", 64'(res_sat), 64'd1);
      check("hold_complete", 64'(res_complete), 64'd1);
      check("hold_seq", 64'(res_seq), 64'd0);
      check("hold_var5", 64'(var_a(5)), 64'd5);
    end
    in_valid = 1'b0;
    hs_a();
    check("hs_drop", 64'(res_valid), 64'd0);
    check("hs_seq", 64'(res_seq), 64'd1);
    check("hs_ready", 64'(in_ready), 64'd1);

    // Out-of-range id then in-range last beat
    chk_x = 1'b0;
    beat_a(6'd55, 8'haa, 1'b0);
    beat_a(6'd3, 8'h72, 1'b1);
    step();
    check("oor_valid", 64'(res_valid), 64'd1);
    check("oor_err", 64'(res_err), 64'd1);
    check("oor_sat", 64'(res_sat), 64'd0);
    check("oor_var3", 64'(var_a(3)), 64'h72);
    check("oor_var2", 64'(var_a(2)), c_clr ? 64'd0 : 64'd2);
    check("oor_var5", 64'(var_a(5)), c_clr ? 64'd0 : 64'd5);
    check("oor_var49", 64'(var_a(49)), c_clr ? 64'd0 : 64'd49);
    check("oor_complete", 64'(res_complete), c_clr ? 64'd0 : 64'd1);
    hs_a();

    // Next assignment writes only id 0; error flag cleared
    chk_x = 1'b1;
    beat_a(6'd0, 8'h5a, 1'b1);
    step();
    check("next_err", 64'(res_err), 64'd0);
    check("next_seq", 64'(res_seq), 64'd2);
    check("next_var0", 64'(var_a(0)), 64'h5a);
    check("next_var10", 64'(var_a(10)), c_clr ? 64'd0 : 64'd10);
    check("next_var3", 64'(var_a(3)), c_clr ? 64'd0 : 64'h72);
    check("next_complete", 64'(res_complete), c_clr ? 64'd0 : 64'd1);
    hs_a();

    // Reset one cycle into EVAL abandons the verdict
    beat_a(6'd1, 8'h11, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("abort_valid", 64'(res_valid), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd1);
    check("abort_bus", 64'(|assign_bus), 64'd0);
    check("abort_seq", 64'(res_seq), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_valid", 64'(res_valid), 64'd0);
    end

    // 256 handshakes wrap the sequence number
    for (int i = 0; i < 256; i++) begin
      beat_a(6'd0, 8'(i), 1'b1);
      step();
      check("wrap_valid", 64'(res_valid), 64'd1);
      check("wrap_seq", 64'(res_seq), 64'(i[7:0]));
      hs_a();
    end
    check("wrap_final_seq", 64'(res_seq), 64'd0);
    check("wrap_final_valid", 64'(res_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/split_assign_driver.md
SPLIT_ASSIGN_DRIVER -- requirements
Module: split_assign_driver

Interface
REQ-001 Parameter NUM_VARS, default 50: number of checker variables; range 1..64.
REQ-002 Parameter VAR_W, default 8: storage width per variable; narrower checker inputs use the low bits.
REQ-003 Parameter CHK_LAT, default 0: checker result latency in cycles, counted from the cycle after assign_bus settles; range 0..15.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  assignment beat valid.
REQ-007 in_ready  output  1  driver accepts a beat.
REQ-008 in_id  input  6  variable index.
REQ-009 in_data  input  VAR_W  variable value.
REQ-010 in_last  input  1  final beat of the assignment; starts evaluation.
REQ-011 assign_bus  output  NUM_VARS*VAR_W  packed variable file; variable k occupies bits [k*VAR_W +: VAR_W]; drives the checker inputs.
REQ-012 chk_x  input  1  checker verdict (the AND of all constraints).
REQ-013 res_valid  output  1  verdict available.
REQ-014 res_ready  input  1  consumer accepts the verdict.
REQ-015 res_sat  output  1  sampled chk_x.
REQ-016 res_complete  output  1  every variable written since the last reset or clear.
REQ-017 res_err  output  1  at least one beat with in_id >= NUM_VARS was received in this assignment.
REQ-018 res_seq  output  8  verdict sequence number.

Function
REQ-019 The FSM SHALL have states LOAD, EVAL and RESP.
REQ-020 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid && in_ready.
REQ-021 An accepted beat with in_id < NUM_VARS SHALL write in_data to variable in_id and set its written bit; it is visible on assign_bus the next cycle.
REQ-022 An accepted beat with in_id >= NUM_VARS SHALL write nothing and SHALL set the sticky error flag.
REQ-023 Accepting a beat with in_last=1 SHALL move the FSM from LOAD to EVAL and load the wait counter with CHK_LAT; the beat's write (if in range) still takes effect.
REQ-024 In EVAL the counter SHALL decrement each cycle; in the cycle the counter reads 0, chk_x SHALL be sampled into res_sat and the FSM SHALL move to RESP, so that res_valid rises CHK_LAT+2 cycles after the in_last handshake.
REQ-025 On entry to RESP, res_complete SHALL latch the AND of all written bits and res_err SHALL latch the error flag.
REQ-026 In RESP, res_valid SHALL be 1 and all res_* outputs SHALL remain stable until res_valid && res_ready.
REQ-027 On the result handshake, res_seq SHALL increment modulo 256 (255 wraps to 0), the error flag SHALL clear, and the FSM SHALL return to LOAD; res_valid SHALL drop in the next cycle.
REQ-028 assign_bus SHALL NOT change in EVAL or RESP.
REQ-029 Without the clear feature (REQ-034), the variable file and written bits SHALL persist across assignments, allowing incremental updates.
REQ-030 A later beat to the same in_id within an assignment SHALL overwrite the earlier value (last write wins).

Reset
REQ-031 rst SHALL force LOAD state; variable file, written bits, error flag, wait counter, res_sat, res_complete, res_err and res_seq SHALL all become 0, and res_valid SHALL become 0.
REQ-032 rst asserted in any state, including mid-EVAL or with res_valid pending, SHALL abandon the operation with no verdict emitted.
REQ-033 in_ready SHALL be 0 during the rst cycle and 1 in the first cycle after rst deasserts.

Configuration
REQ-034 When macro SPLIT_DRV_CLEAR_EN is defined, the result handshake SHALL also zero the variable file and written bits, so each assignment starts from all-zero. When it is undefined, values persist as stated in REQ-029.

Verification
REQ-035 After reset, write ids 0..49 with data = id, the last beat with in_last=1; checker model returns chk_x=1 with CHK_LAT=0 -> res_valid 2 cycles after the last handshake; res_sat=1, res_complete=1, res_err=0, res_seq=0.
REQ-036 Hold res_ready=0 for 5 cycles in RESP while toggling chk_x and driving in_valid -> res_* outputs stable, in_ready=0, assign_bus unchanged; then res_ready=1 -> res_seq=1 on the next verdict.
REQ-037 Send a beat with id 55 (data 8'hAA) followed by id 3 (data 8'h72) with in_last=1 -> res_err=1; variable 3 = 8'h72 on assign_bus; no other variable changes; the next assignment reports res_err=0.
REQ-038 With CHK_LAT=3, write only ids 0..9 -> res_valid 5 cycles after in_last; res_complete=0; res_sat equals chk_x as sampled in that sampling cycle.
REQ-039 Assert rst 1 cycle into EVAL -> no res_valid, assign_bus=0, in_ready=1 in the cycle after rst deasserts; 256 complete handshakes -> res_seq wraps from 255 to 0.
REQ-040 With SPLIT_DRV_CLEAR_EN defined, run two assignments where the second writes only id 0 -> assign_bus is zero except variable 0, and res_complete=0; with the macro undefined -> values from the first assignment are retained and res_complete=1.
